norm_shift_seq: RTL

NORM_SHIFT_SEQ -- requirements
Module: norm_shift_seq

---
 rtl/norm_shift_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/norm_shift_seq.sv
// ============================================================================
// norm_shift_seq : multi-cycle leading-zero count and left-normalize of a 32-bit word.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] norm_out,
  output logic [4:0]  shift_amt,
  output logic        zero_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0] c_coarse_step = 5'd4;
  localparam logic [4:0] c_fine_step   = 5'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_work;
  logic [4:0]  r_count;
  logic [31:0] r_norm;
  logic [4:0]  r_shift;
  logic        r_zero;
  logic        w_accept;
  logic        w_din_zero;
  logic        w_coarse_shift;
  logic        w_fine_shift;

  assign w_accept       = in_valid && (r_state == IDLE);
  assign w_din_zero     = (din == 32'd0);
  assign w_coarse_shift = (r_work[31:28] == 4'd0);
  assign w_fine_shift   = ~r_work[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_next = w_din_zero ? DONE : COARSE;
        COARSE:  if (!w_coarse_shift) w_state_next = FINE;
        FINE:    if (!w_fine_shift) w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Result registers are only written on entry to DONE, so a flush leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= 32'd0;
      r_count <= 5'd0;
      r_norm  <= 32'd0;
      r_shift <= 5'd0;
      r_zero  <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work  <= din;
            r_count <= 5'd0;
            if (w_din_zero) begin
              r_norm  <= 32'd0;
              r_shift <= 5'd0;
              r_zero  <= 1'b1;
            end
          end
        end
        COARSE: begin
          if (w_coarse_shift) begin
            r_work  <= {r_work[27:0], 4'b0000};
            r_count <= r_count + c_coarse_step;
          end
        end
        FINE: begin
          if (w_fine_shift) begin
            r_work  <= {r_work[30:0], 1'b0};
            r_count <= r_count + c_fine_step;
          end else begin
            r_norm  <= r_work;
            r_shift <= r_count;
            r_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign norm_out  = r_norm;
  assign shift_amt = r_shift;
  assign zero_flag = r_zero;

endmodule

`default_nettype wire
